// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end: FSM state encoding,
// next-pc selector, fetch counter width and the default reset word index.
package fetch_pkg;

  localparam int unsigned COUNT_W          = 32;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_STALL,
    ST_HALT,
    ST_ERROR
  } state_t;

  // Which source feeds the pc register on the next edge.
  typedef enum logic [1:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_REDIRECT
  } npc_sel_t;

endpackage

// File: rtl/pc_generator_if.sv
// Fetch request bus between the pc generator (master) and the instruction
// store / pipeline control (slave). Control strobes flow in, pc flows out.
interface pc_generator_if #(
  parameter int WORD_SIZE = 32
);

  logic                         stall;
  logic                         redirect_valid;
  logic [WORD_SIZE-1:0]         redirect_pc;
  logic                         halt;
  logic                         resume;
  logic                         pc_ready;
  logic [WORD_SIZE-1:0]         pc;
  logic                         pc_valid;
  logic                         pc_error;
  logic [fetch_pkg::COUNT_W-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, halt, resume, pc_ready,
    output pc, pc_valid, pc_error, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, halt, resume, pc_ready,
    input  pc, pc_valid, pc_error, fetch_count
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-pc datapath: sequential increment, redirect target, and either
// modulo-REGISTER_SIZE wrapping (default) or range checking when
// PC_BOUNDS_CHECK_EN is defined. Out-of-range flags are independent of the
// selector so the FSM can consult them without a combinational loop.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int REGISTER_SIZE = 64
) (
  input  logic [WORD_SIZE-1:0] i_pc,
  input  npc_sel_t             i_sel,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  output logic [WORD_SIZE-1:0] o_next_pc,
  output logic                 o_inc_out_of_range,
  output logic                 o_redirect_out_of_range
);

  logic [WORD_SIZE-1:0] w_inc_pc;
  assign w_inc_pc = i_pc + WORD_SIZE'(1);

`ifdef PC_BOUNDS_CHECK_EN
  // One extra bit so pc+1 at the top of the word range cannot alias low.
  assign o_inc_out_of_range =
    ({1'b0, i_pc} + (WORD_SIZE+1)'(1)) >= (WORD_SIZE+1)'(REGISTER_SIZE);
  assign o_redirect_out_of_range =
    {1'b0, i_redirect_pc} >= (WORD_SIZE+1)'(REGISTER_SIZE);

  // Pick the next pc; an out-of-range candidate leaves pc where it is.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_next_pc = i_pc;
    case (i_sel)
      NPC_INC:      if (!o_inc_out_of_range)      o_next_pc = w_inc_pc;
      NPC_REDIRECT: if (!o_redirect_out_of_range) o_next_pc = i_redirect_pc;
      default:      o_next_pc = i_pc;
    endcase
  end
`else
  localparam logic [WORD_SIZE-1:0] ADDR_MASK = WORD_SIZE'(REGISTER_SIZE - 1);

  assign o_inc_out_of_range      = 1'b0;
  assign o_redirect_out_of_range = 1'b0;

  // Pick the next pc, folding both sources into the instruction store range.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_next_pc = i_pc;
    case (i_sel)
      NPC_INC:      o_next_pc = w_inc_pc & ADDR_MASK;
      NPC_REDIRECT: o_next_pc = i_redirect_pc & ADDR_MASK;
      default:      o_next_pc = i_pc;
    endcase
  end
`endif

endmodule

// File: rtl/pc_generator.sv
// Program counter generator: BOOT/FETCH/STALL/HALT/ERROR control FSM plus a
// saturating accepted-fetch counter. Per-cycle priority is
// halt > redirect > stall > handshake advance.
// Optional macro PC_BOUNDS_CHECK_EN: out-of-range pc moves go to a sticky
// ERROR state instead of wrapping modulo REGISTER_SIZE.
module pc_generator
  import fetch_pkg::*;
#(
  parameter int                   WORD_SIZE     = 32,
  parameter int                   REGISTER_SIZE = 64,
  parameter logic [WORD_SIZE-1:0] RESET_PC      = WORD_SIZE'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset_n,
  pc_generator_if.master    bus
);

  state_t               r_state;
  state_t               w_state_next;
  npc_sel_t             w_npc_sel;
  logic                 w_accept;
  logic [WORD_SIZE-1:0] r_pc;
  logic [WORD_SIZE-1:0] w_next_pc;
  logic                 w_inc_oor;
  logic                 w_redirect_oor;
  logic [COUNT_W-1:0]   r_fetch_count;
  logic                 w_pc_valid;
  logic                 w_pc_error;

  fetch_next_pc #(
    .WORD_SIZE     (WORD_SIZE),
    .REGISTER_SIZE (REGISTER_SIZE)
  ) u_next_pc (
    .i_pc                    (r_pc),
    .i_sel                   (w_npc_sel),
    .i_redirect_pc           (bus.redirect_pc),
    .o_next_pc               (w_next_pc),
    .o_inc_out_of_range      (w_inc_oor),
    .o_redirect_out_of_range (w_redirect_oor)
  );

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    if (!reset_n) begin
      r_state <= ST_BOOT;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  // Next-state and next-pc source selection, highest priority event first.
  always_comb begin
    w_state_next = r_state;
    w_npc_sel    = NPC_HOLD;
    w_accept     = 1'b0;
    case (r_state)
      ST_BOOT: w_state_next = ST_FETCH;

      ST_FETCH: begin
        if (bus.halt) begin
          w_state_next = ST_HALT;
        end else if (bus.redirect_valid) begin
          w_npc_sel    = NPC_REDIRECT;
          w_state_next = w_redirect_oor ? ST_ERROR : ST_FETCH;
        end else if (bus.stall) begin
          w_state_next = ST_STALL;
        end else if (bus.pc_ready) begin
          w_npc_sel    = NPC_INC;
          w_accept     = 1'b1;
          w_state_next = w_inc_oor ? ST_ERROR : ST_FETCH;
        end
      end

      ST_STALL: begin
        if (bus.halt) begin
          w_state_next = ST_HALT;
        end else if (bus.redirect_valid) begin
          w_npc_sel    = NPC_REDIRECT;
          w_state_next = w_redirect_oor ? ST_ERROR : ST_FETCH;
        end else if (!bus.stall) begin
          w_state_next = ST_FETCH;
        end
      end

      // Stall is ignored here; a simultaneous halt keeps us parked.
      ST_HALT: begin
        if (bus.resume && !bus.halt) begin
          if (bus.redirect_valid) begin
            w_npc_sel    = NPC_REDIRECT;
            w_state_next = w_redirect_oor ? ST_ERROR : ST_FETCH;
          end else begin
            w_state_next = ST_FETCH;
          end
        end
      end

      ST_ERROR: w_state_next = ST_ERROR;

      default: w_state_next = ST_BOOT;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    w_pc_valid = (r_state == ST_FETCH);
`ifdef PC_BOUNDS_CHECK_EN
    w_pc_error = (r_state == ST_ERROR);
`else
    w_pc_error = 1'b0;
`endif
  end

  // PC register and saturating accepted-fetch counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      r_pc <= w_next_pc;
      if (w_accept && (r_fetch_count != COUNT_MAX)) begin
        r_fetch_count <= r_fetch_count + COUNT_W'(1);
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_valid    = w_pc_valid;
  assign bus.pc_error    = w_pc_error;
  assign bus.fetch_count = r_fetch_count;

endmodule
